// File: rtl/regfile_pkg.sv
// Shared widths and types for the CPU general-purpose register file.
package regfile_pkg;

  localparam int unsigned REG_N     = 32;
  localparam int unsigned REG_R     = 7;
  localparam int unsigned REG_DEPTH = 1 << REG_R;

  typedef logic [REG_N-1:0] word_t;
  typedef logic [REG_R-1:0] addr_t;

endpackage

// File: rtl/regfile_word.sv
// One register-file word: load-enabled register with asynchronous active-low clear.
module regfile_word
  import regfile_pkg::*;
#(
  parameter int unsigned W = REG_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// 2**R x N register file: two combinational read ports, one synchronous write port.
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned N = REG_N,
  parameter int unsigned R = REG_R
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         writeEnable,
  input  logic [R-1:0] writeReg,
  input  logic [N-1:0] writeData,
  input  logic [R-1:0] readReg1,
  input  logic [R-1:0] readReg2,
  output logic [N-1:0] readData1,
  output logic [N-1:0] readData2
);

  localparam int unsigned DEPTH = 1 << R;

  logic [DEPTH-1:0] load_en;
  logic [N-1:0]     word_val [DEPTH];

  // One-hot write decode feeding each word's load enable; address 0 is an ordinary register.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign load_en[i] = writeEnable && (writeReg == R'(i));

    regfile_word #(
      .W (N)
    ) u_word (
      .clk    (clk),
      .rst_n  (resetN),
      .load_i (load_en[i]),
      .d_i    (writeData),
      .q_o    (word_val[i])
    );
  end

  // No write-to-read bypass: new data shows up only after the capturing edge.
  assign readData1 = word_val[readReg1];
  assign readData2 = word_val[readReg2];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w.
module tb_reg_file_2r1w;

  localparam int unsigned N = 32;
  localparam int unsigned R = 7;

  logic         clk;
  logic         resetN;
  logic         writeEnable;
  logic [R-1:0] writeReg;
  logic [N-1:0] writeData;
  logic [R-1:0] readReg1;
  logic [R-1:0] readReg2;
  logic [N-1:0] readData1;
  logic [N-1:0] readData2;

  int unsigned n_checks;
  int unsigned n_pass;

  reg_file_2r1w #(
    .N (N),
    .R (R)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .writeEnable (writeEnable),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .readData1   (readData1),
    .readData2   (readData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_both(input logic [R-1:0] a1, input logic [R-1:0] a2);
    readReg1 = a1;
    readReg2 = a2;
    #1;
  endtask

  initial begin
    logic [R-1:0] rst_addrs [3];
    n_checks    = 0;
    n_pass      = 0;
    resetN      = 1'b1;
    writeEnable = 1'b0;
    writeReg    = '0;
    writeData   = '0;
    readReg1    = '0;
    readReg2    = '0;
    rst_addrs[0] = R'(0);
    rst_addrs[1] = R'(64);
    rst_addrs[2] = R'(127);

    // Reset held: all reads zero
    #1 resetN = 1'b0;
    #1;
    foreach (rst_addrs[k]) begin
      read_both(rst_addrs[k], rst_addrs[k]);
      check($sformatf("rst_rd1_a%0d", rst_addrs[k]), readData1, 32'h0);
      check($sformatf("rst_rd2_a%0d", rst_addrs[k]), readData2, 32'h0);
    end
    tick();
    #2 resetN = 1'b1;
    tick();
    tick();
    foreach (rst_addrs[k]) begin
      read_both(rst_addrs[k], rst_addrs[k]);
      check($sformatf("post_rst_rd1_a%0d", rst_addrs[k]), readData1, 32'h0);
      check($sformatf("post_rst_rd2_a%0d", rst_addrs[k]), readData2, 32'h0);
    end

    // Single write then read
    writeEnable = 1'b1;
    writeReg    = R'(102);
    writeData   = 32'h0000_0008;
    tick();
    writeEnable = 1'b0;
    read_both(R'(102), R'(0));
    check("wr102_rd1", readData1, 32'h0000_0008);

    // Sweep: register 64-t gets data t
    for (int t = 0; t < 64; t++) begin
      writeEnable = 1'b1;
      writeReg    = R'(64 - t);
      writeData   = N'(t);
      tick();
    end
    writeEnable = 1'b0;
    for (int t = 1; t < 64; t++) begin
      read_both(R'(102), R'(t));
      check($sformatf("sweep_rd2_a%0d", t), readData2, N'(64 - t));
    end
    read_both(R'(102), R'(64));
    check("sweep_rd2_a64", readData2, 32'h0);
    read_both(R'(102), R'(0));
    check("sweep_rd2_a0", readData2, 32'h0);
    check("sweep_rd1_a102", readData1, 32'h0000_0008);

    // Write disabled must not modify
    writeEnable = 1'b0;
    writeReg    = R'(102);
    writeData   = 32'hDEAD_BEEF;
    tick();
    read_both(R'(102), R'(102));
    check("wdis_rd1_a102", readData1, 32'h0000_0008);
    check("wdis_rd2_a102", readData2, 32'h0000_0008);

    // Read-during-write on address 5 (old value 59)
    read_both(R'(5), R'(5));
    writeEnable = 1'b1;
    writeReg    = R'(5);
    writeData   = 32'hA5A5_A5A5;
    #1;
    check("rdw_pre_rd1", readData1, 32'd59);
    check("rdw_pre_rd2", readData2, 32'd59);
    tick();
    check("rdw_post_rd1", readData1, 32'hA5A5_A5A5);
    check("rdw_post_rd2", readData2, 32'hA5A5_A5A5);
    writeEnable = 1'b0;
    read_both(R'(4), R'(6));
    check("rdw_nbr_a4", readData1, 32'd60);
    check("rdw_nbr_a6", readData2, 32'd58);

    // Async reset between edges with a pending write
    writeEnable = 1'b1;
    writeReg    = R'(7);
    writeData   = 32'h1234_5678;
    read_both(R'(102), R'(5));
    #1 resetN = 1'b0;
    #1;
    check("arst_rd1_a102", readData1, 32'h0);
    check("arst_rd2_a5", readData2, 32'h0);
    tick();
    read_both(R'(7), R'(1));
    check("arst_held_a7", readData1, 32'h0);
    check("arst_held_a1", readData2, 32'h0);
    writeEnable = 1'b0;
    #2 resetN = 1'b1;
    tick();
    read_both(R'(7), R'(63));
    check("arst_rel_a7", readData1, 32'h0);
    check("arst_rel_a63", readData2, 32'h0);

    // Write after reset to address 0 is honoured
    writeEnable = 1'b1;
    writeReg    = R'(0);
    writeData   = 32'hCAFE_0001;
    tick();
    writeEnable = 1'b0;
    read_both(R'(0), R'(0));
    check("a0_wr_rd1", readData1, 32'hCAFE_0001);
    check("a0_wr_rd2", readData2, 32'hCAFE_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
